ddr_wr_burst_seq: RTL

Write-side sequencer for the DDR AXI slave port. It takes a start command (base word address and word count) and a plain valid/ready word stream. It splits the transfer into AXI INCR bursts of at most MAX_BURST beats, drives AW/W/B one burst at a time, and reports busy/done/err. It sits between capture/DMA logic and the DDR_SLAVE_WR_* interface.

---
 rtl/ddr_wr_burst_seq_if.sv | 58 +++++
 rtl/ddr_wr_burst_seq.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/ddr_wr_burst_seq_if.sv
// Bundle for the DDR write sequencer: command, stream and AXI AW/W/B.
// master = sequencer side, slave = command source, stream and AXI slave.
interface ddr_wr_burst_seq_if;
    logic        cmd_start;
    logic [31:0] cmd_addr;
    logic [15:0] cmd_len;
    logic        busy;
    logic        done;
    logic        err;

    logic [31:0] s_data;
    logic        s_valid;
    logic        s_ready;

    logic [3:0]  aw_id;
    logic [31:0] aw_addr;
    logic [7:0]  aw_len;
    logic [1:0]  aw_burst;
    logic        aw_valid;
    logic        aw_ready;

    logic [31:0] w_data;
    logic [3:0]  w_strb;
    logic        w_last;
    logic        w_valid;
    logic        w_ready;

    logic [3:0]  b_id;
    logic [1:0]  b_resp;
    logic        b_valid;
    logic        b_ready;

    modport master (
        input  cmd_start, cmd_addr, cmd_len,
        output busy, done, err,
        input  s_data, s_valid,
        output s_ready,
        output aw_id, aw_addr, aw_len, aw_burst, aw_valid,
        input  aw_ready,
        output w_data, w_strb, w_last, w_valid,
        input  w_ready,
        input  b_id, b_resp, b_valid,
        output b_ready
    );

    modport slave (
        output cmd_start, cmd_addr, cmd_len,
        input  busy, done, err,
        output s_data, s_valid,
        input  s_ready,
        input  aw_id, aw_addr, aw_len, aw_burst, aw_valid,
        output aw_ready,
        input  w_data, w_strb, w_last, w_valid,
        output w_ready,
        output b_id, b_resp, b_valid,
        input  b_ready
    );
endinterface

// File: rtl/ddr_wr_burst_seq.sv
// DDR write sequencer: splits a (word addr, word count) command into AXI
// INCR bursts of at most MAX_BURST beats, one burst outstanding at a time.
// Ports: clk, rst (sync, active high), bus (ddr_wr_burst_seq_if.master):
//   cmd_* start/addr/len in, busy/done/err out; s_* word stream in;
//   aw_*/w_*/b_* AXI write channels.
// Optional: define DDR_WR_SEQ_TIMEOUT_EN to abort WAIT_B after TIMEOUT cycles.
module ddr_wr_burst_seq #(
    parameter int unsigned MAX_BURST = 16,
    parameter logic [3:0]  AXI_ID    = 4'h1,
    parameter int unsigned TIMEOUT   = 1024
) (
    input  logic               clk,
    input  logic               rst,
    ddr_wr_burst_seq_if.master bus
);

    typedef enum logic [2:0] {
        IDLE,
        SEND_AW,
        SEND_W,
        WAIT_B,
        FINISH
    } state_t;

    localparam logic [16:0] MAX_B = 17'(MAX_BURST);

    state_t      state_q;
    logic [31:0] addr_q;
    logic [15:0] rem_q;
    logic [8:0]  beats_q;
    logic [8:0]  beat_cnt_q;
    logic [31:0] aw_addr_q;
    logic [7:0]  aw_len_q;
    logic        aw_valid_q;
    logic        b_ready_q;
    logic        busy_q;
    logic        done_q;
    logic        err_q;

`ifdef DDR_WR_SEQ_TIMEOUT_EN
    logic [31:0] tmo_q;
`else
    logic        unused_timeout;
    assign unused_timeout = |TIMEOUT;
`endif

    logic [8:0]  first_beats_d;
    logic [7:0]  first_len_d;
    logic [31:0] nxt_addr_d;
    logic [15:0] nxt_rem_d;
    logic [8:0]  next_beats_d;
    logic [7:0]  next_len_d;
    logic        in_w;
    logic        w_last;

    // Beats of the next burst: capped by MAX_BURST, by the words left and
    // by the distance to the top of the address space, so no burst wraps.
    function automatic logic [8:0] calc_beats(
        input logic [31:0] addr,
        input logic [15:0] rem
    );
        logic [16:0] b;
        logic [32:0] room;
        b    = ({1'b0, rem} < MAX_B) ? {1'b0, rem} : MAX_B;
        room = 33'h1_0000_0000 - {1'b0, addr};
        if ({16'b0, b} > room) begin
            b = room[16:0];
        end
        return b[8:0];
    endfunction

    always_comb begin
        first_beats_d = calc_beats(bus.cmd_addr, bus.cmd_len);
        first_len_d   = 8'(first_beats_d - 9'd1);
        nxt_addr_d    = addr_q + {23'b0, beats_q};
        nxt_rem_d     = rem_q - {7'b0, beats_q};
        next_beats_d  = calc_beats(nxt_addr_d, nxt_rem_d);
        next_len_d    = 8'(next_beats_d - 9'd1);
    end

    assign in_w   = (state_q == SEND_W);
    assign w_last = in_w && (beat_cnt_q == beats_q - 9'd1);

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
    assign bus.s_ready  = in_w & bus.w_ready;
    assign bus.aw_id    = AXI_ID;
    assign bus.aw_addr  = aw_addr_q;
    assign bus.aw_len   = aw_len_q;
    assign bus.aw_burst = 2'b01;
    assign bus.aw_valid = aw_valid_q;
    assign bus.w_data   = bus.s_data;
    assign bus.w_strb   = 4'hF;
    assign bus.w_last   = w_last;
    assign bus.w_valid  = in_w & bus.s_valid;
    assign bus.b_ready  = b_ready_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            rem_q      <= '0;
            beats_q    <= '0;
            beat_cnt_q <= '0;
            aw_addr_q  <= '0;
            aw_len_q   <= '0;
            aw_valid_q <= 1'b0;
            b_ready_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef DDR_WR_SEQ_TIMEOUT_EN
            tmo_q      <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.cmd_start) begin
                        busy_q <= 1'b1;
                        err_q  <= 1'b0;
                        if (bus.cmd_len == 16'd0) begin
                            state_q <= FINISH;
                        end else begin
                            addr_q     <= bus.cmd_addr;
                            rem_q      <= bus.cmd_len;
                            beats_q    <= first_beats_d;
                            aw_addr_q  <= bus.cmd_addr;
                            aw_len_q   <= first_len_d;
                            aw_valid_q <= 1'b1;
                            state_q    <= SEND_AW;
                        end
                    end
                end
                SEND_AW: begin
                    if (bus.aw_ready) begin
                        aw_valid_q <= 1'b0;
                        beat_cnt_q <= '0;
                        state_q    <= SEND_W;
                    end
                end
                SEND_W: begin
                    if (bus.s_valid && bus.w_ready) begin
                        beat_cnt_q <= beat_cnt_q + 9'd1;
                        if (w_last) begin
                            b_ready_q <= 1'b1;
                            state_q   <= WAIT_B;
`ifdef DDR_WR_SEQ_TIMEOUT_EN
                            tmo_q     <= '0;
`endif
                        end
                    end
                end
                WAIT_B: begin
                    if (bus.b_valid) begin
                        b_ready_q <= 1'b0;
                        err_q     <= err_q | (bus.b_resp != 2'b00)
                                           | (bus.b_id != AXI_ID);
                        addr_q    <= nxt_addr_d;
                        rem_q     <= nxt_rem_d;
                        if (nxt_rem_d == 16'd0) begin
                            state_q <= FINISH;
                        end else begin
                            beats_q    <= next_beats_d;
                            aw_addr_q  <= nxt_addr_d;
                            aw_len_q   <= next_len_d;
                            aw_valid_q <= 1'b1;
                            state_q    <= SEND_AW;
                        end
                    end
`ifdef DDR_WR_SEQ_TIMEOUT_EN
                    else if (tmo_q == TIMEOUT - 1) begin
                        b_ready_q <= 1'b0;
                        err_q     <= 1'b1;
                        state_q   <= FINISH;
                    end else begin
                        tmo_q <= tmo_q + 32'd1;
                    end
`endif
                end
                FINISH: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
